vme_system_arbiter: RTL and testbench

//  VME slot-1 system controller: arbitrates BR0..BR3 onto the BG daisy chains and monitors BBSY and BCLR.
//  It also runs the global bus timer, driving BERR when no slave answers an AS cycle.
//  It sits beside vme_bus_arbitration, whose requester side consumes the BG chains this block drives.

---
 rtl/vme_system_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vme_system_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_system_arbiter.sv
// VME slot-1 system controller: BR0..BR3 arbitration onto the BG daisy chains, BCLR, global bus timer.
// Build option VME_ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed priority.
module vme_system_arbiter #(
    parameter int GRANT_TIMEOUT = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int BUS_TIMEOUT   = 640,
    parameter int TIMER_WIDTH   = 10
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [3:0] i_vme_br,
    input  logic       i_vme_bbsy,
    input  logic       i_vme_as,
    input  logic       i_vme_dtack,
    input  logic       i_vme_berr_in,
    output logic [3:0] o_vme_bg_out,
    output logic       o_vme_bclr,
    output logic       o_vme_berr_out,
    output logic [1:0] o_arb_owner,
    output logic       o_arb_timeout
);

    localparam int GW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [GW-1:0]          GNT_LOAD = GW'(GRANT_TIMEOUT - 1);
    localparam logic [SW-1:0]          SET_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] BT_FIRE  = TIMER_WIDTH'(BUS_TIMEOUT - 2);
    localparam logic [TIMER_WIDTH-1:0] BT_SAT   = TIMER_WIDTH'(BUS_TIMEOUT - 1);

    // state  | meaning
    // IDLE   | no grant out; grant the winning level when BBSY is released
    // GRANT  | BG low to r_owner, waiting for the requester to take BBSY
    // BUSY   | bus owned; BCLR asked for when a stronger request waits
    // SETTLE | all BG high for SETTLE_CYCLES before the next grant
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY, ST_SETTLE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_sync1, r_sync2;
    logic [3:0]             r_bg, w_bg_nxt;
    logic [1:0]             r_owner, w_owner_nxt, w_win;
    logic                   r_bclr, w_bclr_nxt, w_bclr_req;
    logic [GW-1:0]          r_gnt_cnt, w_gnt_nxt;
    logic [SW-1:0]          r_set_cnt, w_set_nxt;
    logic [TIMER_WIDTH-1:0] r_bt_cnt;
    logic                   r_berr, r_tmo;
    logic [3:0]             w_pend;
    logic                   w_bbsy, w_as, w_dtack, w_berr_in, w_bt_run, w_bt_fire;

    // Everything idles high, so the synchronisers reset to the inactive level.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {i_vme_br, i_vme_bbsy, i_vme_as, i_vme_dtack, i_vme_berr_in};
            r_sync2 <= r_sync1;
        end
    end

    assign w_pend    = ~r_sync2[7:4];
    assign w_bbsy    = r_sync2[3];
    assign w_as      = r_sync2[2];
    assign w_dtack   = r_sync2[1];
    assign w_berr_in = r_sync2[0];

    always_comb begin
        w_win      = r_owner;
        w_bclr_req = 1'b0;
`ifdef VME_ARB_ROUND_ROBIN_EN
        // Last hit wins, so walking k downward makes owner-1 the strongest candidate.
        for (int k = 4; k >= 1; k--) begin
            if (w_pend[r_owner - 2'(k)]) w_win = r_owner - 2'(k);
        end
        w_bclr_req = |(w_pend & ~(4'b0001 << r_owner));
`else
        for (int i = 0; i < 4; i++) begin
            if (w_pend[i]) w_win = 2'(i);
            if (w_pend[i] && (2'(i) > r_owner)) w_bclr_req = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bg_nxt    = 4'hF;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = r_gnt_cnt;
        w_set_nxt   = r_set_cnt;
        w_bclr_nxt  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if ((|w_pend) && w_bbsy) begin
                    w_bg_nxt          = 4'hF;
                    w_bg_nxt[w_win]   = 1'b0;
                    w_owner_nxt       = w_win;
                    w_gnt_nxt         = GNT_LOAD;
                    w_state_nxt       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!w_bbsy) begin
                    w_state_nxt = ST_BUSY;
                    w_bclr_nxt  = ~w_bclr_req;
                end else if (!w_pend[r_owner] || (r_gnt_cnt == '0)) begin
                    w_set_nxt   = SET_LOAD;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_bg_nxt  = r_bg;
                    w_gnt_nxt = r_gnt_cnt - 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_bbsy) begin
                    w_set_nxt   = SET_LOAD;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_bclr_nxt = ~w_bclr_req;
                end
            end
            ST_SETTLE: begin
                if (r_set_cnt == '0) w_state_nxt = ST_IDLE;
                else                 w_set_nxt   = r_set_cnt - 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_bg      <= 4'hF;
            r_owner   <= 2'd0;
            r_bclr    <= 1'b1;
            r_gnt_cnt <= '0;
            r_set_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bg      <= w_bg_nxt;
            r_owner   <= w_owner_nxt;
            r_bclr    <= w_bclr_nxt;
            r_gnt_cnt <= w_gnt_nxt;
            r_set_cnt <= w_set_nxt;
        end
    end

    // Bus timer: saturating, cleared by AS release or any slave response.
    assign w_bt_run  = !w_as && w_dtack && w_berr_in;
    assign w_bt_fire = w_bt_run && (r_bt_cnt == BT_FIRE);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bt_cnt <= '0;
            r_berr   <= 1'b1;
            r_tmo    <= 1'b0;
        end else begin
            r_tmo <= w_bt_fire;
            if (!w_bt_run)              r_bt_cnt <= '0;
            else if (r_bt_cnt != BT_SAT) r_bt_cnt <= r_bt_cnt + 1'b1;
            if (w_as)           r_berr <= 1'b1;
            else if (w_bt_fire) r_berr <= 1'b0;
        end
    end

    assign o_vme_bg_out   = r_bg;
    assign o_vme_bclr     = r_bclr;
    assign o_vme_berr_out = r_berr;
    assign o_arb_owner    = r_owner;
    assign o_arb_timeout  = r_tmo;

endmodule

// File: tb/tb_vme_system_arbiter.sv
// Self-checking bench for vme_system_arbiter: directed scenarios plus randomized arbitration rounds.
// Expected grants/BCLR come from a level-ordering model; define VME_ARB_ROUND_ROBIN_EN to match an RR build.
module tb_vme_system_arbiter;

    localparam int GT = 16;
    localparam int SC = 2;
    localparam int BT = 640;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] br = 4'hF;
    logic       bbsy = 1'b1;
    logic       as_l = 1'b1;
    logic       dtack = 1'b1;
    logic       berr_in = 1'b1;
    logic [3:0] bg;
    logic       bclr;
    logic       berr_out;
    logic [1:0] owner;
    logic       tmo;

    int n_tests = 0;
    int n_fail  = 0;
    int m_owner, w, cnt, hi_cnt, first_low, pulses, lows, ok;
    logic       tmo_first;
    logic [3:0] pend, pend2, ebg;

    vme_system_arbiter #(
        .GRANT_TIMEOUT(GT),
        .SETTLE_CYCLES(SC),
        .BUS_TIMEOUT  (BT),
        .TIMER_WIDTH  (10)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_vme_br      (br),
        .i_vme_bbsy    (bbsy),
        .i_vme_as      (as_l),
        .i_vme_dtack   (dtack),
        .i_vme_berr_in (berr_in),
        .o_vme_bg_out  (bg),
        .o_vme_bclr    (bclr),
        .o_vme_berr_out(berr_out),
        .o_arb_owner   (owner),
        .o_arb_timeout (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Winner among pending levels given the level granted last.
    function automatic int exp_win(input logic [3:0] p, input int own);
`ifdef VME_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (p[(own - k + 8) % 4]) return (own - k + 8) % 4;
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (p[i]) return i;
        end
`endif
        return own;
    endfunction

    // Active-low BCLR level expected while the bus is busy.
    function automatic logic exp_bclr(input logic [3:0] p, input int own);
        for (int i = 0; i < 4; i++) begin
`ifdef VME_ARB_ROUND_ROBIN_EN
            if (p[i] && i != own) return 1'b0;
`else
            if (p[i] && i > own) return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bg(input logic [3:0] exp, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bg === exp) break;
        end
        chk(tag, {28'd0, bg}, {28'd0, exp});
    endtask

    task automatic grant_vec(input int lvl, output logic [3:0] v);
        v = 4'hF;
        v[lvl] = 1'b0;
    endtask

    task automatic as_window(input int total, input int raise_at, input int resp_at, input bit use_berr);
        first_low = 0; pulses = 0; lows = 0; tmo_first = 1'b0;
        as_l = 1'b0;
        for (int i = 1; i <= total; i++) begin
            if (i == resp_at) begin
                if (use_berr) berr_in = 1'b0;
                else          dtack   = 1'b0;
            end
            if (i == raise_at) as_l = 1'b1;
            @(negedge clk);
            if (berr_out === 1'b0) begin
                lows++;
                if (first_low == 0) begin
                    first_low = i;
                    tmo_first = tmo;
                end
            end
            if (tmo === 1'b1) pulses++;
        end
    endtask

    task automatic bus_idle();
        as_l = 1'b1; dtack = 1'b1; berr_in = 1'b1;
        cycles(5);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bg"},    {28'd0, bg}, 32'hF);
        chk({tag, "_bclr"},  {31'd0, bclr}, 32'd1);
        chk({tag, "_berr"},  {31'd0, berr_out}, 32'd1);
        chk({tag, "_owner"}, {30'd0, owner}, 32'd0);
        chk({tag, "_tmo"},   {31'd0, tmo}, 32'd0);
    endtask

    initial begin
        cycles(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        m_owner = 0;
        cycles(3);

        // T5: all levels requesting, successive bus releases
        br = 4'h0;
        for (int it = 0; it < 5; it++) begin
            w = exp_win(4'hF, m_owner);
            grant_vec(w, ebg);
            wait_bg(ebg, 12, "t5_grant");
            chk("t5_owner", {30'd0, owner}, w);
            m_owner = w;
            bbsy = 1'b0;
            wait_bg(4'hF, 3, "t5_busy");
            bbsy = 1'b1;
        end
        br = 4'hF;
        cycles(10);
        chk("t5_idle", {28'd0, bg}, 32'hF);

        // T1: levels 3 and 1 requesting
        pend = 4'b1010;
        br = ~pend;
        w = exp_win(pend, m_owner);
        grant_vec(w, ebg);
        wait_bg(ebg, 3, "t1_grant");
        chk("t1_owner", {30'd0, owner}, w);
        m_owner = w;
        bbsy = 1'b0;
        wait_bg(4'hF, 3, "t1_busy");
        cycles(3);
        chk("t1_bclr", {31'd0, bclr}, {31'd0, exp_bclr(pend, m_owner)});
        br = 4'hF; bbsy = 1'b1;
        cycles(10);
        chk("t1_idle", {28'd0, bg}, 32'hF);

        // T2: grant never taken, withdrawn after GT cycles, then re-offered after settling
        br = 4'b1101;
        wait_bg(4'b1101, 3, "t2_grant");
        m_owner = 1;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bg === 4'b1101) cnt++;
            else break;
        end
        chk("t2_grant_len", cnt, GT);
        chk("t2_withdrawn", {28'd0, bg}, 32'hF);
        chk("t2_owner_kept", {30'd0, owner}, 32'd1);
        hi_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bg === 4'hF) hi_cnt++;
            else break;
        end
        ok = (hi_cnt >= SC && hi_cnt <= SC + 3) ? 1 : 0;
        chk("t2_settle_gap", ok, 1);
        chk("t2_regrant", {28'd0, bg}, 32'hD);
        br = 4'hF;
        wait_bg(4'hF, 3, "t2_br_release");
        cycles(8);

        // T3: owner 1 busy, level 2 arrives -> BCLR
        br = 4'b1101;
        wait_bg(4'b1101, 3, "t3_grant");
        m_owner = 1;
        bbsy = 1'b0;
        wait_bg(4'hF, 3, "t3_busy");
        chk("t3_bclr_idle", {31'd0, bclr}, 32'd1);
        br = 4'b1001;
        cycles(3);
        chk("t3_bclr_on", {31'd0, bclr}, 32'd0);
        br = 4'b1011; bbsy = 1'b1;
        cycles(3);
        chk("t3_bclr_off", {31'd0, bclr}, 32'd1);
        w = exp_win(4'b0100, m_owner);
        grant_vec(w, ebg);
        wait_bg(ebg, 10, "t3_next_grant");
        chk("t3_owner", {30'd0, owner}, w);
        m_owner = w;
        bbsy = 1'b0;
        wait_bg(4'hF, 3, "t3_busy2");
        br = 4'hF; bbsy = 1'b1;
        cycles(8);

        // Randomized arbitration rounds
        for (int it = 0; it < 20; it++) begin
            pend = 4'($urandom_range(1, 15));
            br = ~pend;
            w = exp_win(pend, m_owner);
            grant_vec(w, ebg);
            wait_bg(ebg, 3, "rnd_grant");
            chk("rnd_owner", {30'd0, owner}, w);
            m_owner = w;
            bbsy = 1'b0;
            wait_bg(4'hF, 3, "rnd_busy");
            chk("rnd_bclr_entry", {31'd0, bclr}, {31'd0, exp_bclr(pend, m_owner)});
            pend2 = 4'($urandom_range(0, 15));
            br = ~pend2;
            cycles(3);
            chk("rnd_bclr", {31'd0, bclr}, {31'd0, exp_bclr(pend2, m_owner)});
            br = 4'hF; bbsy = 1'b1;
            cycles(8);
            chk("rnd_idle", {28'd0, bg}, 32'hF);
        end

        // T4: bus timer fires with no response
        as_window(660, 0, 0, 1'b0);
        ok = (first_low >= BT && first_low <= BT + 3) ? 1 : 0;
        chk("t4_fire_time", ok, 1);
        chk("t4_tmo_with_berr", {31'd0, tmo_first}, 32'd1);
        chk("t4_one_pulse", pulses, 1);
        chk("t4_berr_held", {31'd0, berr_out}, 32'd0);
        as_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (berr_out === 1'b1) break;
        end
        chk("t4_berr_clear", {31'd0, berr_out}, 32'd1);
        bus_idle();

        as_window(700, 0, 100, 1'b0);
        chk("t4_dtack_no_berr", lows, 0);
        chk("t4_dtack_no_pulse", pulses, 0);
        bus_idle();

        as_window(700, BT - 5, 0, 1'b0);
        chk("t4_short_as", lows, 0);
        bus_idle();

        as_window(700, 0, $urandom_range(5, 600), 1'($urandom_range(0, 1)));
        chk("t4_rnd_resp", lows + pulses, 0);
        bus_idle();

        // T6: asynchronous reset mid-grant and while BERR is driven
        br = 4'b1110;
        wait_bg(4'b1110, 3, "t6_grant");
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t6_grant_rst");
        @(negedge clk);
        rst_n = 1'b1;
        br = 4'hF;
        m_owner = 0;
        cycles(4);
        as_l = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (berr_out === 1'b0) break;
        end
        chk("t6_berr_low", {31'd0, berr_out}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t6_berr_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
